// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: pad command encodings, arbiter state type and
// default bus widths used by the command arbiter slice.
package sdram_pkg;

    localparam int ADDR_W_DEFAULT = 13;
    localparam int BA_W_DEFAULT   = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP         = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE   = 4'b0010;
    localparam logic [3:0] CMD_REFRESH     = 4'b0001;
    localparam logic [3:0] CMD_MODEREG_SET = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE      = 4'b0011;
    localparam logic [3:0] CMD_WRITE       = 4'b0100;
    localparam logic [3:0] CMD_READ        = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } arb_state_e;

endpackage

// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle of init-sequencer, engine handshake and pad signals around the
// SDRAM command arbiter. slave = arbiter side, master = engines/pads side.
interface sdram_cmd_arbiter_if
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int BA_W   = BA_W_DEFAULT
);

    logic              init_end_flag;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;

    logic              ref_en;
    logic              ref_done;
    logic [3:0]        ref_cmd;

    logic              wr_req;
    logic              wr_en;
    logic              wr_done;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;

    logic              rd_req;
    logic              rd_en;
    logic              rd_done;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;

    logic [3:0]        sdram_cmd;
    logic [BA_W-1:0]   sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;
    logic              ref_miss;

    modport slave (
        input  init_end_flag, init_cmd, init_addr,
        input  ref_done, ref_cmd,
        input  wr_req, wr_done, wr_cmd, wr_ba, wr_addr,
        input  rd_req, rd_done, rd_cmd, rd_ba, rd_addr,
        output ref_en, wr_en, rd_en,
        output sdram_cmd, sdram_ba, sdram_addr, ref_miss
    );

    modport master (
        output init_end_flag, init_cmd, init_addr,
        output ref_done, ref_cmd,
        output wr_req, wr_done, wr_cmd, wr_ba, wr_addr,
        output rd_req, rd_done, rd_cmd, rd_ba, rd_addr,
        input  ref_en, wr_en, rd_en,
        input  sdram_cmd, sdram_ba, sdram_addr, ref_miss
    );

endinterface

// File: rtl/sdram_ref_timer.sv
// Periodic auto-refresh request generator with sticky missed-refresh flag.
// Counter is held at zero until initialisation has completed.
module sdram_ref_timer #(
    parameter int REF_CYCLES = 780
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic init_end_flag_i,
    input  logic aref_entry_i,
    output logic ref_req_o,
    output logic ref_miss_o
);

    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ref_req_q, ref_req_d;
    logic             ref_miss_q, ref_miss_d;
    logic             tc;

    // Interval counter and request/miss bookkeeping; a terminal count on the
    // AREF-entry cycle re-arms the request instead of counting as a miss.
    always_comb begin
        tc         = init_end_flag_i && (cnt_q == CNT_LAST);
        cnt_d      = '0;
        if (init_end_flag_i && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
        ref_req_d  = tc | (ref_req_q & ~aref_entry_i);
        ref_miss_d = ref_miss_q | (tc & ref_req_q & ~aref_entry_i);
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            ref_req_q  <= 1'b0;
            ref_miss_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ref_req_q  <= ref_req_d;
            ref_miss_q <= ref_miss_d;
        end
    end

    assign ref_req_o  = ref_req_q;
    assign ref_miss_o = ref_miss_q;

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command/address pin owner: passes the init sequencer through until
// init completes, then grants the pins to refresh, write or read engines.
module sdram_cmd_arbiter
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = 780,
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int BA_W       = BA_W_DEFAULT
) (
    input logic               sysclk_100M,
    input logic               rst,
    sdram_cmd_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              first_q, first_d;
    logic              last_wr_q, last_wr_d;
    logic              ref_en_q, wr_en_q, rd_en_q;
    logic              ref_req;
    logic              ref_miss;
    logic              aref_entry;
    logic [3:0]        pad_cmd;
    logic [BA_W-1:0]   pad_ba;
    logic [ADDR_W-1:0] pad_addr;

    sdram_ref_timer #(
        .REF_CYCLES (REF_CYCLES)
    ) u_ref_timer (
        .clk_i           (sysclk_100M),
        .rst_i           (rst),
        .init_end_flag_i (bus.init_end_flag),
        .aref_entry_i    (aref_entry),
        .ref_req_o       (ref_req),
        .ref_miss_o      (ref_miss)
    );

    // Next-state: refresh first, then round-robin between write and read.
    // first_q marks the entry cycle, when the engine cannot yet have seen
    // its enable, so a done there is stale and ignored.
    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        aref_entry = 1'b0;
        case (state_q)
            ST_INIT:  if (bus.init_end_flag) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (ref_req) begin
                    state_d    = ST_AREF;
                    aref_entry = 1'b1;
                end else if (bus.wr_req && (!bus.rd_req || !last_wr_q)) begin
                    state_d   = ST_WRITE;
                    last_wr_d = 1'b1;
                end else if (bus.rd_req) begin
                    state_d   = ST_READ;
                    last_wr_d = 1'b0;
                end
            end
            ST_AREF:  if (!first_q && bus.ref_done) state_d = ST_ARBIT;
            ST_WRITE: if (!first_q && bus.wr_done)  state_d = ST_ARBIT;
            ST_READ:  if (!first_q && bus.rd_done)  state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
        first_d = (state_q == ST_ARBIT) && (state_d != ST_ARBIT);
    end

    // State and registered grant enables.
    always_ff @(posedge sysclk_100M or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            first_q   <= 1'b0;
            last_wr_q <= 1'b0;
            ref_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            last_wr_q <= last_wr_d;
            ref_en_q  <= (state_d == ST_AREF);
            wr_en_q   <= (state_d == ST_WRITE);
            rd_en_q   <= (state_d == ST_READ);
        end
    end

    // Pad mux selected by the registered owner.
    always_comb begin
        pad_cmd  = CMD_NOP;
        pad_ba   = '0;
        pad_addr = '0;
        case (state_q)
            ST_INIT: begin
                pad_cmd  = bus.init_cmd;
                pad_addr = bus.init_addr;
            end
            ST_AREF:  pad_cmd = bus.ref_cmd;
            ST_WRITE: begin
                pad_cmd  = bus.wr_cmd;
                pad_ba   = bus.wr_ba;
                pad_addr = bus.wr_addr;
            end
            ST_READ: begin
                pad_cmd  = bus.rd_cmd;
                pad_ba   = bus.rd_ba;
                pad_addr = bus.rd_addr;
            end
            default: ;
        endcase
    end

    assign bus.ref_en     = ref_en_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.ref_miss   = ref_miss;
    assign bus.sdram_cmd  = pad_cmd;
    assign bus.sdram_ba   = pad_ba;
    assign bus.sdram_addr = pad_addr;

endmodule
